program_loader: RTL and testbench



---
 rtl/program_loader_if.sv | 27 ++
 rtl/program_loader.sv | 95 +++++++++
 tb/tb_program_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Front-panel load bus: operator key/switch inputs and the memory write handshake.
interface program_loader_if #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
);
  logic                  Enable;
  logic                  Strobe;
  logic                  SetAddr;
  logic [WIDTH/2-1:0]    DataIn;
  logic                  MemAck;
  logic [ADDR_WIDTH-1:0] MemAddr;
  logic [WIDTH-1:0]      MemData;
  logic                  MemWrite;
  logic                  ProcHold;
  logic                  Phase;
  logic                  Full;

  modport slave (
    input  Enable, Strobe, SetAddr, DataIn, MemAck,
    output MemAddr, MemData, MemWrite, ProcHold, Phase, Full
  );

  modport master (
    output Enable, Strobe, SetAddr, DataIn, MemAck,
    input  MemAddr, MemData, MemWrite, ProcHold, Phase, Full
  );
endinterface

// File: rtl/program_loader.sv
// Assembles keyed bytes into words and writes them to processor memory with
// auto-increment, holding the processor while load mode is active.
module program_loader #(
  parameter int WIDTH      = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic           Clock,
  input  logic           Reset,
  program_loader_if.slave bus
);
  localparam int HALF = WIDTH / 2;

  typedef enum logic [1:0] {
    ST_HIGH,
    ST_LOW,
    ST_WRITE
  } state_t;

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [WIDTH-1:0]      mem_data_reg;
  logic                  mem_write_reg;
  logic                  full_reg;
  logic [ADDR_WIDTH-1:0] strobe_addr;

  // Switch byte fitted to the address width
  generate
    if (ADDR_WIDTH > HALF) begin : g_addr_ext
      assign strobe_addr = {{(ADDR_WIDTH - HALF){1'b0}}, bus.DataIn};
    end else begin : g_addr_trunc
      assign strobe_addr = bus.DataIn[ADDR_WIDTH-1:0];
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_HIGH;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
      mem_write_reg <= 1'b0;
      full_reg      <= 1'b0;
    end else begin
      case (state_reg)
        ST_HIGH: begin
          if (bus.Enable && bus.Strobe) begin
            if (bus.SetAddr) begin
              mem_addr_reg <= strobe_addr;
              full_reg     <= 1'b0;
            end else if (!full_reg) begin
              mem_data_reg[WIDTH-1:HALF] <= bus.DataIn;
              state_reg                  <= ST_LOW;
            end
          end
        end
        ST_LOW: begin
          // Leaving load mode drops the half-assembled word
          if (!bus.Enable) begin
            state_reg <= ST_HIGH;
          end else if (bus.Strobe) begin
            if (bus.SetAddr) begin
              mem_addr_reg <= strobe_addr;
              full_reg     <= 1'b0;
              state_reg    <= ST_HIGH;
            end else begin
              mem_data_reg[HALF-1:0] <= bus.DataIn;
              mem_write_reg          <= 1'b1;
              state_reg              <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          // Strobes here are dropped; only the ack moves the FSM on
          if (bus.MemAck) begin
            mem_write_reg <= 1'b0;
            state_reg     <= ST_HIGH;
            if (mem_addr_reg == '1) begin
              full_reg     <= 1'b1;
              mem_addr_reg <= '0;
            end else begin
              mem_addr_reg <= mem_addr_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_HIGH;
      endcase
    end
  end

  assign bus.MemAddr  = mem_addr_reg;
  assign bus.MemData  = mem_data_reg;
  assign bus.MemWrite = mem_write_reg;
  assign bus.Full     = full_reg;
  assign bus.Phase    = (state_reg == ST_LOW);
  assign bus.ProcHold = bus.Enable | (state_reg == ST_WRITE);
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; memory writes are checked by a scoreboard
// monitor at each acknowledged request, state outputs by direct checks.
module tb_program_loader;
  logic clk;
  logic rst;
  int   checks;
  int   passes;
  logic [23:0] sb[$];

  program_loader_if #(.WIDTH(16), .ADDR_WIDTH(8)) bus ();

  program_loader #(.WIDTH(16), .ADDR_WIDTH(8)) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Outputs settle 2 time units after each rising edge; inputs change there too
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [7:0] d, input logic sa);
    bus.DataIn  = d;
    bus.SetAddr = sa;
    bus.Strobe  = 1'b1;
    tick();
    bus.Strobe  = 1'b0;
    bus.SetAddr = 1'b0;
    $display("strobe data=%h setaddr=%0b -> addr=%h data=%h phase=%0b write=%0b full=%0b",
             d, sa, bus.MemAddr, bus.MemData, bus.Phase, bus.MemWrite, bus.Full);
  endtask

  task automatic ack();
    bus.MemAck = 1'b1;
    tick();
    bus.MemAck = 1'b0;
  endtask

  // Scoreboard monitor: the ack about to be sampled completes the pending write
  always @(negedge clk) begin
    if (!rst && bus.MemWrite && bus.MemAck) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", {8'h0, bus.MemAddr, bus.MemData}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = sb.pop_front();
        $display("write addr=%h data=%h (expect addr=%h data=%h)",
                 bus.MemAddr, bus.MemData, e[23:16], e[15:0]);
        chk("wr_addr", {24'h0, bus.MemAddr}, {24'h0, e[23:16]});
        chk("wr_data", {16'h0, bus.MemData}, {16'h0, e[15:0]});
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.Enable = 1'b0;
    bus.Strobe = 1'b0;
    bus.SetAddr = 1'b0;
    bus.DataIn = '0;
    bus.MemAck = 1'b0;
    tick();
    tick();
    chk("rst_addr", {24'h0, bus.MemAddr}, 32'h0);
    chk("rst_data", {16'h0, bus.MemData}, 32'h0);
    chk("rst_write", {31'h0, bus.MemWrite}, 32'h0);
    chk("rst_full", {31'h0, bus.Full}, 32'h0);
    chk("rst_phase", {31'h0, bus.Phase}, 32'h0);
    chk("rst_hold", {31'h0, bus.ProcHold}, 32'h0);
    rst = 1'b0;
    tick();

    // Basic word with a slow ack
    bus.Enable = 1'b1;
    tick();
    chk("en_hold", {31'h0, bus.ProcHold}, 32'h1);
    chk("en_addr", {24'h0, bus.MemAddr}, 32'h0);
    strobe(8'h12, 1'b0);
    chk("hi_phase", {31'h0, bus.Phase}, 32'h1);
    chk("hi_byte", {24'h0, bus.MemData[15:8]}, 32'h12);
    sb.push_back({8'h00, 16'h1234});
    strobe(8'h34, 1'b0);
    chk("lo_data", {16'h0, bus.MemData}, 32'h1234);
    chk("lo_write", {31'h0, bus.MemWrite}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_write", {31'h0, bus.MemWrite}, 32'h1);
      chk("wait_data", {16'h0, bus.MemData}, 32'h1234);
    end
    ack();
    chk("ack_write", {31'h0, bus.MemWrite}, 32'h0);
    chk("ack_addr", {24'h0, bus.MemAddr}, 32'h01);
    chk("ack_phase", {31'h0, bus.Phase}, 32'h0);

    // Address set and wrap at the top of memory
    strobe(8'hFE, 1'b1);
    chk("set_addr", {24'h0, bus.MemAddr}, 32'hFE);
    chk("set_phase", {31'h0, bus.Phase}, 32'h0);
    chk("set_data", {16'h0, bus.MemData}, 32'h1234);
    sb.push_back({8'hFE, 16'hAAAA});
    strobe(8'hAA, 1'b0);
    strobe(8'hAA, 1'b0);
    ack();
    chk("fe_addr", {24'h0, bus.MemAddr}, 32'hFF);
    chk("fe_full", {31'h0, bus.Full}, 32'h0);
    sb.push_back({8'hFF, 16'h5555});
    strobe(8'h55, 1'b0);
    strobe(8'h55, 1'b0);
    ack();
    chk("wrap_full", {31'h0, bus.Full}, 32'h1);
    chk("wrap_addr", {24'h0, bus.MemAddr}, 32'h00);
    strobe(8'h33, 1'b0);
    chk("full_ign_phase", {31'h0, bus.Phase}, 32'h0);
    chk("full_ign_data", {16'h0, bus.MemData}, 32'h5555);

    // SetAddr clears Full
    strobe(8'h10, 1'b1);
    chk("clr_full", {31'h0, bus.Full}, 32'h0);
    chk("clr_addr", {24'h0, bus.MemAddr}, 32'h10);
    chk("clr_phase", {31'h0, bus.Phase}, 32'h0);
    strobe(8'h77, 1'b0);
    chk("accept_phase", {31'h0, bus.Phase}, 32'h1);

    // Enable drop discards the partial word
    bus.Enable = 1'b0;
    tick();
    chk("drop_phase", {31'h0, bus.Phase}, 32'h0);
    chk("drop_hold", {31'h0, bus.ProcHold}, 32'h0);
    chk("drop_data", {16'h0, bus.MemData}, 32'h7755);
    bus.Enable = 1'b1;
    sb.push_back({8'h10, 16'h0102});
    strobe(8'h01, 1'b0);
    strobe(8'h02, 1'b0);
    chk("reen_data", {16'h0, bus.MemData}, 32'h0102);

    // Enable drop during WRITE, ack together with a strobe
    bus.Enable = 1'b0;
    tick();
    chk("wr_drop_hold", {31'h0, bus.ProcHold}, 32'h1);
    chk("wr_drop_write", {31'h0, bus.MemWrite}, 32'h1);
    bus.MemAck = 1'b1;
    bus.Strobe = 1'b1;
    bus.DataIn = 8'h99;
    tick();
    bus.MemAck = 1'b0;
    bus.Strobe = 1'b0;
    chk("wr_drop_hold_after", {31'h0, bus.ProcHold}, 32'h0);
    chk("wr_drop_addr", {24'h0, bus.MemAddr}, 32'h11);
    chk("wr_drop_phase", {31'h0, bus.Phase}, 32'h0);

    // Stray ack outside WRITE
    bus.Enable = 1'b1;
    bus.MemAck = 1'b1;
    tick();
    bus.MemAck = 1'b0;
    chk("stray_ack_addr", {24'h0, bus.MemAddr}, 32'h11);

    // Ack and strobe in the same WRITE cycle with load mode still on
    sb.push_back({8'h11, 16'hABCD});
    strobe(8'hAB, 1'b0);
    strobe(8'hCD, 1'b0);
    bus.MemAck = 1'b1;
    bus.Strobe = 1'b1;
    bus.DataIn = 8'hEE;
    tick();
    bus.MemAck = 1'b0;
    bus.Strobe = 1'b0;
    chk("ackstb_phase", {31'h0, bus.Phase}, 32'h0);
    chk("ackstb_addr", {24'h0, bus.MemAddr}, 32'h12);
    chk("ackstb_data", {16'h0, bus.MemData}, 32'hABCD);

    // Strobe coinciding with Enable fall in LOW
    strobe(8'h44, 1'b0);
    bus.Enable = 1'b0;
    bus.Strobe = 1'b1;
    bus.DataIn = 8'h55;
    tick();
    bus.Strobe = 1'b0;
    chk("enfall_phase", {31'h0, bus.Phase}, 32'h0);
    chk("enfall_write", {31'h0, bus.MemWrite}, 32'h0);
    chk("enfall_data", {16'h0, bus.MemData}, 32'h44CD);

    // Asynchronous reset in the middle of a write
    bus.Enable = 1'b1;
    strobe(8'hC3, 1'b0);
    strobe(8'h3C, 1'b0);
    chk("pre_rst_write", {31'h0, bus.MemWrite}, 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_write", {31'h0, bus.MemWrite}, 32'h0);
    chk("arst_addr", {24'h0, bus.MemAddr}, 32'h0);
    chk("arst_data", {16'h0, bus.MemData}, 32'h0);
    chk("arst_full", {31'h0, bus.Full}, 32'h0);
    chk("arst_phase", {31'h0, bus.Phase}, 32'h0);
    chk("arst_hold", {31'h0, bus.ProcHold}, 32'h1);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_phase", {31'h0, bus.Phase}, 32'h0);
    chk("sb_empty", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
